// File: rtl/frame_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | frame_pkg: shared state encoding, header default, channel search |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HEADER  = 3'd3,
        ST_DATA    = 3'd4,
        ST_CKSUM   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    // Lowest set mask bit at or above start; 8 means no channel left.
    function automatic logic [3:0] next_enabled(input logic [7:0] mask,
                                                input logic [3:0] start);
        logic [3:0] res;
        res = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= start)) res = 4'(i);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ch_next_find.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ch_next_find: next enabled channel at/above start, plus none flag|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ch_next_find
    import frame_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CW     = $clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CW-1:0]     start,
    output logic [CW-1:0]     idx,
    output logic              none
);

    logic [3:0] res;

    always_comb begin
        res  = next_enabled(8'(mask), 4'(start));
        idx  = CW'(res);
        none = (res >= 4'(NUM_CH));
    end

endmodule
`default_nettype wire

// File: rtl/frame_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | frame_serializer: reads enabled FIFO channels, emits header/data/ |
// | checksum bytes over a valid/ready byte stream. Revision: 1.0      |
// +------------------------------------------------------------------+
module frame_serializer
    import frame_pkg::*;
#(
    parameter int         NUM_CH   = 4,
    parameter int         CH_BYTES = 2,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT,
    parameter bit         CKSUM_EN = 1'b1
) (
    input  logic                         clk40M,
    input  logic                         nRst,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic [NUM_CH-1:0]            empty,
    output logic [NUM_CH-1:0]            rd,
    input  logic [NUM_CH*CH_BYTES*8-1:0] fifoOut,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic                         frame_done,
    output logic [15:0]                  frame_cnt
);

    localparam int CW = $clog2(NUM_CH + 1);
    localparam int BW = $clog2(CH_BYTES + 1);
    localparam int DW = NUM_CH * CH_BYTES * 8;

    state_t            state;
    logic [NUM_CH-1:0] act_mask;
    logic [DW-1:0]     cap;
    logic [CW-1:0]     ch;
    logic [BW-1:0]     byte_idx;
    logic [7:0]        cksum;

    logic              last_byte;
    logic [CW-1:0]     nf_start;
    logic [CW-1:0]     nf_idx;
    logic              nf_none;
    logic [CW-1:0]     sel_ch;
    logic [BW-1:0]     sel_byte;
    logic [7:0]        next_byte;
    logic [7:0]        cksum_next;

    ch_next_find #(
        .NUM_CH (NUM_CH),
        .CW     (CW)
    ) u_find (
        .mask  (act_mask),
        .start (nf_start),
        .idx   (nf_idx),
        .none  (nf_none)
    );

    // Pre-select the byte that follows the one on tx_data, so it is ready
    // to load on the accepting edge and transfers can run back to back.
    always_comb begin
        last_byte  = (byte_idx == BW'(CH_BYTES - 1));
        nf_start   = (state == ST_HEADER) ? '0 : CW'(ch + CW'(1));
        sel_ch     = ch;
        sel_byte   = BW'(byte_idx + BW'(1));
        if (state == ST_HEADER || last_byte) begin
            sel_ch   = nf_idx;
            sel_byte = '0;
        end
        next_byte  = cap[(int'(sel_ch) * CH_BYTES + int'(sel_byte)) * 8 +: 8];
        cksum_next = cksum ^ tx_data;
    end

    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            state      <= ST_IDLE;
            act_mask   <= '0;
            cap        <= '0;
            ch         <= '0;
            byte_idx   <= '0;
            cksum      <= '0;
            rd         <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ch_mask != '0 && (ch_mask & empty) == '0) begin
                        act_mask <= ch_mask;
                        rd       <= ch_mask;
                        busy     <= 1'b1;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    rd    <= '0;
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    cap      <= fifoOut;
                    tx_data  <= HDR_BYTE;
                    tx_valid <= 1'b1;
                    state    <= ST_HEADER;
                end
                ST_HEADER: begin
                    if (tx_ready) begin
                        ch       <= nf_idx;
                        byte_idx <= '0;
                        tx_data  <= next_byte;
                        cksum    <= '0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tx_ready) begin
                        cksum <= cksum_next;
                        if (!last_byte) begin
                            byte_idx <= BW'(byte_idx + BW'(1));
                            tx_data  <= next_byte;
                        end else if (!nf_none) begin
                            ch       <= nf_idx;
                            byte_idx <= '0;
                            tx_data  <= next_byte;
                        end else if (CKSUM_EN) begin
                            tx_data <= cksum_next;
                            state   <= ST_CKSUM;
                        end else begin
                            tx_valid   <= 1'b0;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_CKSUM: begin
                    if (tx_ready) begin
                        tx_valid   <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
